// File: rtl/iig_pkg.sv
// Shared constants and types for the integral-image rectangle reader.
// Optional request checking is enabled by defining IIG_RECT_CHECK_EN.
package iig_pkg;

  localparam int unsigned DEF_IMG_W  = 80;
  localparam int unsigned DEF_IMG_H  = 60;
  localparam int unsigned DEF_RD_LAT = 2;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 21;
  localparam int unsigned ACC_W      = 22;
  localparam int unsigned X_W        = 7;
  localparam int unsigned Y_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Corner issue order: A(x0-1,y0-1), B(x1,y0-1), C(x0-1,y1), D(x1,y1)
  typedef enum logic [1:0] {
    CRN_A = 2'd0,
    CRN_B = 2'd1,
    CRN_C = 2'd2,
    CRN_D = 2'd3
  } corner_e;

  typedef struct packed {
    logic valid;
    logic neg;
  } tag_t;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
  } rect_t;

  // B and C are subtracted from the sum; A and D are added
  function automatic logic corner_neg(input corner_e c);
    return (c == CRN_B) || (c == CRN_C);
  endfunction

endpackage

// File: rtl/iig_addr_gen.sv
// Registered (x,y) -> linear IIGBRAM address; holds its value when not enabled.
module iig_addr_gen
  import iig_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

  // Address = y*IMG_W + x, updated only on a read strobe
  always_comb begin
    addr_d = addr_q;
    if (en) begin
      addr_d = ADDR_W'(ADDR_W'(y) * ADDR_W'(IMG_W)) + ADDR_W'(x);
    end
  end

  // Address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/iig_rect_reader.sv
// Rectangle-sum reader for the integral-image BRAM: S = D - B - C + A.
// Define IIG_RECT_CHECK_EN to reject malformed or out-of-range rectangles.
module iig_rect_reader
  import iig_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iRun,
  input  logic              iReq_valid,
  output logic              oReq_ready,
  input  logic [X_W-1:0]    iX0,
  input  logic [X_W-1:0]    iX1,
  input  logic [Y_W-1:0]    iY0,
  input  logic [Y_W-1:0]    iY1,
  output logic              oRdreq_to_IIGBRAM,
  output logic [ADDR_W-1:0] oAddr_to_IIGBRAM,
  input  logic [DATA_W-1:0] iData,
  output logic              oSum_valid,
  input  logic              iSum_ready,
  output logic [DATA_W-1:0] oSum,
  output logic              oErr
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 4) + 1;

  if (IMG_W * IMG_H > (1 << ADDR_W) || RD_LAT < 1) begin : g_bad_cfg
    $error("iig_rect_reader: image does not fit the address space or RD_LAT is zero");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  rect_t                    rect_q, rect_d;
  logic                     rdreq_q, rdreq_d;
  logic                     neg_q, neg_d;
  tag_t [RD_LAT-1:0]        tag_q, tag_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sum_valid_q, sum_valid_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic                     bad_req;
  logic                     issuing;
  logic                     corner_live;
  rect_t                    req_in;
  rect_t                    op;
  corner_e                  corner;
  logic [X_W-1:0]           cx;
  logic [Y_W-1:0]           cy;
  tag_t                     tag_out;

  assign req_in     = '{x0: iX0, y0: iY0, x1: iX1, y1: iY1};
  assign oReq_ready = iRun && (state_q == ST_IDLE);
  assign accept     = iReq_valid && oReq_ready;

`ifdef IIG_RECT_CHECK_EN
  assign bad_req = (iX0 > iX1) || (iY0 > iY1) ||
                   (32'(iX1) >= IMG_W) || (32'(iY1) >= IMG_H);
`else
  assign bad_req = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic; dropping iRun always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = bad_req ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (cnt_q == CNT_W'(4)) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = ST_DONE;
      ST_DONE:  if (iSum_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!iRun) state_d = ST_IDLE;
  end

  // Output / datapath next values: corner selection, tag pipeline, accumulator
  always_comb begin
    rect_d      = rect_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    sum_valid_d = 1'b0;
    tag_out     = tag_q[RD_LAT-1];

    tag_d[0] = tag_t'{valid: rdreq_q, neg: neg_q};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    // The first corner is issued straight from the request ports so it leaves at T+1
    op     = accept ? req_in : rect_q;
    corner = accept ? CRN_A : corner_e'(cnt_q[1:0]);
    cx     = ((corner == CRN_A) || (corner == CRN_C)) ? op.x0 - X_W'(1) : op.x1;
    cy     = ((corner == CRN_A) || (corner == CRN_B)) ? op.y0 - Y_W'(1) : op.y1;
    corner_live = ((corner == CRN_B) || (corner == CRN_D) || (op.x0 != '0)) &&
                  ((corner == CRN_C) || (corner == CRN_D) || (op.y0 != '0));
    issuing = (accept && !bad_req) ||
              ((state_q == ST_ISSUE) && (cnt_q < CNT_W'(4)));
    rdreq_d = issuing && corner_live;
    neg_d   = corner_neg(corner);

    if (tag_out.valid) begin
      if (tag_out.neg) acc_d = acc_q - ACC_W'(iData);
      else             acc_d = acc_q + ACC_W'(iData);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rect_d = req_in;
          cnt_d  = CNT_W'(1);
          acc_d  = '0;
          err_d  = bad_req;
        end
      end
      ST_ISSUE: cnt_d = (cnt_q == CNT_W'(4)) ? '0 : cnt_q + CNT_W'(1);
      ST_DRAIN: cnt_d = cnt_q + CNT_W'(1);
      default:  ;
    endcase

    if (state_d != ST_DONE) err_d = 1'b0;
    sum_valid_d = (state_d == ST_DONE);

    // Abort: drop issued reads and forget anything still in flight
    if (!iRun) begin
      rdreq_d = 1'b0;
      neg_d   = 1'b0;
      tag_d   = '0;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rect_q      <= '0;
      cnt_q       <= '0;
      rdreq_q     <= 1'b0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
      acc_q       <= '0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rect_q      <= rect_d;
      cnt_q       <= cnt_d;
      rdreq_q     <= rdreq_d;
      neg_q       <= neg_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      sum_valid_q <= sum_valid_d;
      err_q       <= err_d;
    end
  end

  iig_addr_gen #(.IMG_W(IMG_W)) u_addr_gen (
    .clk   (iClk),
    .rst_n (iReset_n),
    .en    (rdreq_d),
    .x     (cx),
    .y     (cy),
    .addr  (oAddr_to_IIGBRAM)
  );

  assign oRdreq_to_IIGBRAM = rdreq_q;
  assign oSum_valid        = sum_valid_q;
  assign oSum              = acc_q[DATA_W-1:0];
  assign oErr              = err_q;

endmodule

// File: tb/tb_iig_rect_reader.sv
// Bench for iig_rect_reader: IIGBRAM model with 2-cycle latency, pixel-level sum reference.
module tb_iig_rect_reader;

  logic        clk = 1'b0;
  logic        rst_n, run, req_valid, req_ready, rdreq, sum_valid, sum_ready, err;
  logic [6:0]  x0, x1;
  logic [5:0]  y0, y1;
  logic [12:0] addr;
  logic [20:0] data, sum;

  always #5 clk = ~clk;

  iig_rect_reader dut (
    .iClk              (clk),
    .iReset_n          (rst_n),
    .iRun              (run),
    .iReq_valid        (req_valid),
    .oReq_ready        (req_ready),
    .iX0               (x0),
    .iX1               (x1),
    .iY0               (y0),
    .iY1               (y1),
    .oRdreq_to_IIGBRAM (rdreq),
    .oAddr_to_IIGBRAM  (addr),
    .iData             (data),
    .oSum_valid        (sum_valid),
    .iSum_ready        (sum_ready),
    .oSum              (sum),
    .oErr              (err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Image, BRAM contents and read log
  int          pix [60][80];
  logic [20:0] mem [8192];
  int unsigned rd_log[$];
  int unsigned exp_log[$];
  logic [20:0] bram_p1;

  // BRAM: data appears two cycles after the read strobe; garbage otherwise
  always @(posedge clk) begin
    if (rdreq) begin
      bram_p1 <= mem[addr];
      rd_log.push_back(32'(addr));
    end else begin
      bram_p1 <= 21'($urandom);
    end
    data <= bram_p1;
  end

  function automatic void fill_pix(input int mode);
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++)
        pix[y][x] = (mode == 0) ? 1 : (mode == 1) ? 255 : int'($urandom_range(0, 255));
  endfunction

  function automatic void build_mem();
    int row_acc;
    for (int i = 0; i < 8192; i++) mem[i] = 21'($urandom);
    for (int y = 0; y < 60; y++) begin
      row_acc = 0;
      for (int x = 0; x < 80; x++) begin
        row_acc += pix[y][x];
        mem[y*80 + x] = 21'(row_acc + ((y > 0) ? int'(mem[(y-1)*80 + x]) : 0));
      end
    end
  endfunction

  function automatic int unsigned ref_sum(input int xa, input int ya, input int xb, input int yb);
    int unsigned s = 0;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        s += 32'(pix[y][x]);
    return s;
  endfunction

  function automatic void ref_reads(input int xa, input int ya, input int xb, input int yb);
    exp_log = {};
    if (xa > 0 && ya > 0) exp_log.push_back(32'((ya-1)*80 + xa - 1));
    if (ya > 0)           exp_log.push_back(32'((ya-1)*80 + xb));
    if (xa > 0)           exp_log.push_back(32'(yb*80 + xa - 1));
    exp_log.push_back(32'(yb*80 + xb));
  endfunction

  int          lat, last_waited;
  logic [20:0] last_sum;

  // Present a request at a negedge and wait until it will be accepted at the next posedge
  task automatic send_req(input int xa, input int ya, input int xb, input int yb);
    x0 = 7'(xa); y0 = 6'(ya); x1 = 7'(xb); y1 = 6'(yb);
    req_valid   = 1'b1;
    last_waited = 0;
    while (!req_ready && last_waited < 40) begin
      @(negedge clk);
      last_waited++;
    end
    check("req_accept", 32'(req_ready), 1);
    rd_log = {};
  endtask

  task automatic run_rect(input string nm, input int xa, input int ya, input int xb, input int yb,
                          input int hold, input int exp_lat, input logic exp_err,
                          input logic chk_data);
    int unsigned exp_sum;
    logic        busy_ok;
    exp_sum = exp_err ? 0 : ref_sum(xa, ya, xb, yb);
    if (exp_err) exp_log = {};
    else         ref_reads(xa, ya, xb, yb);
    send_req(xa, ya, xb, yb);
    busy_ok = 1'b1;
    lat     = 0;
    while (!sum_valid || lat == 0) begin
      if (lat >= 40) break;
      @(negedge clk);
      if (lat == 0) req_valid = 1'b0;
      lat++;
      if (!sum_valid && req_ready) busy_ok = 1'b0;
    end
    check({nm, "_busy_not_ready"}, 32'(busy_ok), 1);
    check({nm, "_valid"}, 32'(sum_valid), 1);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_err"}, 32'(err), 32'(exp_err));
    last_sum = sum;
    if (chk_data) begin
      check({nm, "_sum"}, 32'(sum), exp_sum);
      check({nm, "_nreads"}, 32'(rd_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < rd_log.size(); i++)
        check({nm, "_addr"}, rd_log[i], exp_log[i]);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(sum_valid), 1);
      check({nm, "_hold_ready"}, 32'(req_ready), 0);
      if (chk_data) check({nm, "_hold_sum"}, 32'(sum), exp_sum);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check({nm, "_consumed"}, 32'(sum_valid), 0);
  endtask

  initial begin
    int xa, ya, xb, yb;
    rst_n = 1'b0; run = 1'b0; req_valid = 1'b0; sum_ready = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    fill_pix(0);
    build_mem();
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready), 0);
    check("rst_rdreq",  32'(rdreq), 0);
    check("rst_addr",   32'(addr), 0);
    check("rst_valid",  32'(sum_valid), 0);
    check("rst_sum",    32'(sum), 0);
    check("rst_err",    32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("norun_ready", 32'(req_ready), 0);
    run = 1'b1;
    #1;
    check("run_ready", 32'(req_ready), 1);
    @(negedge clk);

    // All-ones image: basic rectangle and edge-masked corners
    run_rect("t1", 2, 3, 5, 6, 0, 7, 1'b0, 1'b1);
    check("t1_const", 32'(last_sum), 16);
    run_rect("t2a", 0, 0, 3, 3, 0, 7, 1'b0, 1'b1);
    check("t2a_const", 32'(last_sum), 16);
    run_rect("t2b", 0, 2, 1, 4, 1, 7, 1'b0, 1'b1);
    check("t2b_const", 32'(last_sum), 6);

    // Full image at 255 with consumer back-pressure
    fill_pix(1);
    build_mem();
    run_rect("t3", 0, 0, 79, 59, 5, 7, 1'b0, 1'b1);
    check("t3_const", 32'(last_sum), 1224000);

    // Back-to-back requests on a random image
    fill_pix(2);
    build_mem();
    run_rect("t4a", 3, 7, 50, 40, 0, 7, 1'b0, 1'b1);
    run_rect("t4b", 0, 9, 79, 12, 0, 7, 1'b0, 1'b1);
    check("t4_b2b_wait", 32'(last_waited), 0);

    // Abort at T+3, then restart immediately while stale data returns
    send_req(10, 5, 40, 30);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("t5_no_valid", 32'(sum_valid), 0);
    check("t5_norun_ready", 32'(req_ready), 0);
    run = 1'b1;
    #1;
    check("t5_ready_back", 32'(req_ready), 1);
    run_rect("t5", 1, 1, 20, 15, 0, 7, 1'b0, 1'b1);

    // Malformed rectangle
`ifdef IIG_RECT_CHECK_EN
    run_rect("t6", 5, 0, 4, 2, 0, 1, 1'b1, 1'b1);
    check("t6_sum0", 32'(last_sum), 0);
`else
    run_rect("t6", 5, 0, 4, 2, 0, 7, 1'b0, 1'b0);
`endif

    // Random rectangles with random back-pressure
    for (int n = 0; n < 30; n++) begin
      xa = int'($urandom_range(0, 79)); xb = int'($urandom_range(xa, 79));
      ya = int'($urandom_range(0, 59)); yb = int'($urandom_range(ya, 59));
      run_rect("rnd", xa, ya, xb, yb, int'($urandom_range(0, 3)), 7, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
